// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, round-count helper, FSM encoding and
// the GF(2^8) arithmetic behind the S-box and MixColumns.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;
  typedef logic [3:0]           aes_kidx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_LAST  = 2'd2,
    ST_DONE  = 2'd3
  } aes_fsm_e;

  function automatic int unsigned aes_nr(input int unsigned key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] aes_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = aes_xtime(sh);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = aes_gf_mul(x, x);
    x3   = aes_gf_mul(x2, x);
    x12  = aes_gf_mul(aes_gf_mul(x3, x3), aes_gf_mul(x3, x3));
    x15  = aes_gf_mul(x12, x3);
    x240 = aes_gf_mul(x15, x15);
    x240 = aes_gf_mul(x240, x240);
    x240 = aes_gf_mul(x240, x240);
    x240 = aes_gf_mul(x240, x240);
    inv  = aes_gf_mul(aes_gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte i of a block sits at bits [AES_BLK_W-1-8*i -: 8]; column c holds bytes 4c..4c+3.
module sub_byte import aes_pkg::*; (
  input  aes_blk_t iData,
  output aes_blk_t oData
);
  always_comb begin
    oData = '0;
    for (int unsigned i = 0; i < 16; i++)
      oData[AES_BLK_W-1-8*i -: 8] = aes_sbox(iData[AES_BLK_W-1-8*i -: 8]);
  end
endmodule

module shift_rows import aes_pkg::*; (
  input  aes_blk_t iData,
  output aes_blk_t oData
);
  always_comb begin
    oData = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        oData[AES_BLK_W-1-8*(4*c+r) -: 8] = iData[AES_BLK_W-1-8*(4*((c+r)%4)+r) -: 8];
  end
endmodule

module mix_columns import aes_pkg::*; (
  input  aes_blk_t iData,
  output aes_blk_t oData
);
  logic [7:0] a0, a1, a2, a3;
  always_comb begin
    oData = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = iData[AES_BLK_W-1-8*(4*c)   -: 8];
      a1 = iData[AES_BLK_W-1-8*(4*c+1) -: 8];
      a2 = iData[AES_BLK_W-1-8*(4*c+2) -: 8];
      a3 = iData[AES_BLK_W-1-8*(4*c+3) -: 8];
      oData[AES_BLK_W-1-8*(4*c)   -: 8] = aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3;
      oData[AES_BLK_W-1-8*(4*c+1) -: 8] = a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3;
      oData[AES_BLK_W-1-8*(4*c+2) -: 8] = a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3;
      oData[AES_BLK_W-1-8*(4*c+3) -: 8] = aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3);
    end
  end
endmodule

module add_round_key import aes_pkg::*; (
  input  aes_blk_t iData,
  input  aes_blk_t iKey,
  output aes_blk_t oData
);
  assign oData = iData ^ iKey;
endmodule

module aes_round_comb import aes_pkg::*; (
  input  aes_blk_t iState,
  input  aes_blk_t iKey,
  input  logic     iLast,
  output aes_blk_t oState
);
  aes_blk_t sb_out, sr_out, mc_out, pre_key;

  sub_byte      u_sub_byte    (.iData(iState), .oData(sb_out));
  shift_rows    u_shift_rows  (.iData(sb_out), .oData(sr_out));
  mix_columns   u_mix_columns (.iData(sr_out), .oData(mc_out));

  assign pre_key = iLast ? sr_out : mc_out;

  add_round_key u_add_round_key (.iData(pre_key), .iKey(iKey), .oData(oState));
endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES encryption core: one round per enabled cycle on a shared datapath,
// round keys fetched combinationally by index from an external schedule.
module aes_round_iter import aes_pkg::*; #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iEn,
  input  logic         iStart,
  input  logic         iAbort,
  input  logic [0:127] iState,
  input  logic [0:127] iKey,
  output logic [3:0]   oKeyIdx,
  output logic [0:127] oState,
  output logic         oBusy,
  output logic         oDone
);

  localparam int unsigned NR = aes_nr(KEY_BITS);
  localparam aes_kidx_t NR_IDX   = aes_kidx_t'(NR);
  localparam aes_kidx_t PRE_LAST = aes_kidx_t'(NR - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_round_iter: KEY_BITS must be 128, 192 or 256");
  end

  aes_fsm_e  fsm_q, fsm_d;
  aes_kidx_t cnt_q, cnt_d;
  aes_blk_t  blk_q, blk_d;
  aes_blk_t  out_q, out_d;
  aes_blk_t  key_blk, start_blk, round_out;

  assign key_blk   = iKey;
  assign start_blk = iState;

  aes_round_comb u_round (
    .iState (blk_q),
    .iKey   (key_blk),
    .iLast  (fsm_q == ST_LAST),
    .oState (round_out)
  );

  // Abort overrides every transition, including a start in IDLE.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    blk_d = blk_q;
    out_d = out_q;
    if (iEn) begin
      if (iAbort) begin
        fsm_d = ST_IDLE;
        cnt_d = '0;
      end else begin
        case (fsm_q)
          ST_IDLE: begin
            if (iStart) begin
              blk_d = start_blk ^ key_blk;
              cnt_d = aes_kidx_t'(1);
              fsm_d = ST_ROUND;
            end
          end
          ST_ROUND: begin
            blk_d = round_out;
            if (cnt_q == PRE_LAST) begin
              cnt_d = NR_IDX;
              fsm_d = ST_LAST;
            end else begin
              cnt_d = cnt_q + aes_kidx_t'(1);
            end
          end
          ST_LAST: begin
            blk_d = round_out;
            out_d = round_out;
            fsm_d = ST_DONE;
          end
          default: begin
            cnt_d = '0;
            fsm_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fsm_q <= ST_IDLE;
      cnt_q <= '0;
      blk_q <= '0;
      out_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
      out_q <= out_d;
    end
  end

  always_comb begin
    case (fsm_q)
      ST_IDLE: oKeyIdx = '0;
      ST_LAST: oKeyIdx = NR_IDX;
      default: oKeyIdx = cnt_q;
    endcase
  end

  assign oState = out_q;
  assign oBusy  = (fsm_q == ST_ROUND) || (fsm_q == ST_LAST);
  assign oDone  = (fsm_q == ST_DONE);

endmodule

// File: tb/tb_aes_round_iter.sv
// Directed bench for aes_round_iter: FIPS-197 vectors for all key sizes, stall,
// back-to-back, abort and reset scenarios, with a local key-schedule model.
module tb_aes_round_iter;

  logic         iClk = 1'b0;
  logic         iRst_n, iEn, iStart, iAbort;
  logic [0:127] iState;
  logic [0:127] key128, key192, key256;
  logic [3:0]   idx128, idx192, idx256;
  logic [0:127] st128, st192, st256;
  logic         busy128, busy192, busy256;
  logic         done128, done192, done256;

  int errors = 0;
  int checks = 0;
  int sel    = 0;

  logic [127:0] rks [0:3][0:15];
  logic [7:0]   sbox [0:255];
  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 iClk = ~iClk;

  always_comb begin
    key128 = rks[sel][idx128];
    key192 = rks[1][idx192];
    key256 = rks[2][idx256];
  end

  aes_round_iter #(.KEY_BITS(128)) u_dut128 (
    .iClk(iClk), .iRst_n(iRst_n), .iEn(iEn), .iStart(iStart), .iAbort(iAbort),
    .iState(iState), .iKey(key128), .oKeyIdx(idx128), .oState(st128),
    .oBusy(busy128), .oDone(done128));
  aes_round_iter #(.KEY_BITS(192)) u_dut192 (
    .iClk(iClk), .iRst_n(iRst_n), .iEn(iEn), .iStart(iStart), .iAbort(iAbort),
    .iState(iState), .iKey(key192), .oKeyIdx(idx192), .oState(st192),
    .oBusy(busy192), .oDone(done192));
  aes_round_iter #(.KEY_BITS(256)) u_dut256 (
    .iClk(iClk), .iRst_n(iRst_n), .iEn(iEn), .iStart(iStart), .iAbort(iAbort),
    .iState(iState), .iKey(key256), .oKeyIdx(idx256), .oState(st256),
    .oBusy(busy256), .oDone(done256));

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input int set, input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rks[set][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic sync_idle();
    iStart = 1'b0;
    iEn    = 1'b1;
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; iEn = 1'b1; iStart = 1'b0; iAbort = 1'b0; iState = '0;
    tick(); tick();
    checks++; if (st128 !== 128'h0) begin errors++; $display("FAIL reset_ostate got=%h exp=0", st128); end
    checks++; if (idx128 !== 4'd0) begin errors++; $display("FAIL reset_keyidx got=%0d exp=0", idx128); end
    checks++; if (busy128 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy128); end
    checks++; if (done128 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done128); end
    checks++; if (st256 !== 128'h0) begin errors++; $display("FAIL reset_ostate256 got=%h exp=0", st256); end
    iRst_n = 1'b1;
    tick();
    checks++; if (busy128 !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy128); end
  endtask

  task automatic test_fips();
    int d128, d192, d256;
    d128 = -1; d192 = -1; d256 = -1;
    sync_idle();
    sel = 0; iState = PT_C; iStart = 1'b1;
    checks++; if (idx128 !== 4'd0) begin errors++; $display("FAIL fips_idx0 got=%0d exp=0", idx128); end
    tick();
    iStart = 1'b0; iState = '0;
    for (int c = 1; c <= 16; c++) begin
      if (c <= 10) begin
        checks++; if (idx128 !== 4'(c)) begin errors++; $display("FAIL fips_idx cyc=%0d got=%0d exp=%0d", c, idx128, c); end
      end
      if (c == 1) begin
        checks++; if (busy128 !== 1'b1) begin errors++; $display("FAIL fips_busy got=%b exp=1", busy128); end
      end
      if (done128 && d128 < 0) d128 = c;
      if (done192 && d192 < 0) d192 = c;
      if (done256 && d256 < 0) d256 = c;
      tick();
    end
    checks++; if (d128 != 11) begin errors++; $display("FAIL fips_done128 got=%0d exp=11", d128); end
    checks++; if (d192 != 13) begin errors++; $display("FAIL fips_done192 got=%0d exp=13", d192); end
    checks++; if (d256 != 15) begin errors++; $display("FAIL fips_done256 got=%0d exp=15", d256); end
    checks++; if (st128 !== C1) begin errors++; $display("FAIL fips_ct128 got=%h exp=%h", st128, C1); end
    checks++; if (st192 !== C2) begin errors++; $display("FAIL fips_ct192 got=%h exp=%h", st192, C2); end
    checks++; if (st256 !== C3) begin errors++; $display("FAIL fips_ct256 got=%h exp=%h", st256, C3); end
  endtask

  task automatic test_back_to_back();
    logic         exp_done;
    logic [127:0] exp_st;
    sync_idle();
    sel = 3; iState = PT_B; iStart = 1'b1;
    tick();
    iState = PT_C;
    for (int c = 1; c <= 24; c++) begin
      exp_done = (c == 11) || (c == 23);
      exp_st   = (c < 11) ? C1 : ((c < 23) ? CB : C1);
      checks++; if (done128 !== exp_done) begin errors++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", c, done128, exp_done); end
      checks++; if (st128 !== exp_st) begin errors++; $display("FAIL b2b_ostate cyc=%0d got=%h exp=%h", c, st128, exp_st); end
      if (c == 12) begin
        checks++; if (idx128 !== 4'd0) begin errors++; $display("FAIL b2b_idx12 got=%0d exp=0", idx128); end
      end
      if (c == 13) begin
        checks++; if (idx128 !== 4'd1) begin errors++; $display("FAIL b2b_idx13 got=%0d exp=1", idx128); end
      end
      if (c == 11) sel = 0;
      if (c == 23) iStart = 1'b0;
      tick();
    end
  endtask

  task automatic test_abort();
    int d;
    sel = 3;
    sync_idle();
    iState = PT_B; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    checks++; if (busy128 !== 1'b0) begin errors++; $display("FAIL abort_round_busy got=%b exp=0", busy128); end
    checks++; if (idx128 !== 4'd0) begin errors++; $display("FAIL abort_round_idx got=%0d exp=0", idx128); end
    for (int c = 7; c <= 14; c++) begin
      checks++; if (done128 !== 1'b0) begin errors++; $display("FAIL abort_round_done cyc=%0d got=%b exp=0", c, done128); end
      checks++; if (st128 !== C1) begin errors++; $display("FAIL abort_round_ostate cyc=%0d got=%h exp=%h", c, st128, C1); end
      tick();
    end
    sync_idle();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (9) tick();
    checks++; if (idx128 !== 4'd10) begin errors++; $display("FAIL abort_last_idx got=%0d exp=10", idx128); end
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    for (int c = 11; c <= 13; c++) begin
      checks++; if (done128 !== 1'b0) begin errors++; $display("FAIL abort_last_done cyc=%0d got=%b exp=0", c, done128); end
      checks++; if (st128 !== C1) begin errors++; $display("FAIL abort_last_ostate cyc=%0d got=%h exp=%h", c, st128, C1); end
      tick();
    end
    sync_idle();
    iAbort = 1'b1; iStart = 1'b1;
    tick();
    iAbort = 1'b0; iStart = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      checks++; if (busy128 !== 1'b0 || done128 !== 1'b0) begin errors++; $display("FAIL abort_start cyc=%0d busy=%b done=%b exp=0", c, busy128, done128); end
      tick();
    end
    d = -1;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (done128 && d < 0) d = c;
      tick();
    end
    checks++; if (d != 11) begin errors++; $display("FAIL abort_rerun_done got=%0d exp=11", d); end
    checks++; if (st128 !== CB) begin errors++; $display("FAIL abort_rerun_ct got=%h exp=%h", st128, CB); end
  endtask

  task automatic test_stall();
    int d, e;
    sync_idle();
    sel = 0; iState = PT_C; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    e = 1; d = -1;
    for (int c = 1; c <= 20 && d < 0; c++) begin
      if (done128) begin
        d = c;
      end else begin
        checks++; if (idx128 !== 4'(e)) begin errors++; $display("FAIL stall_idx cyc=%0d got=%0d exp=%0d", c, idx128, e); end
        checks++; if (st128 !== CB) begin errors++; $display("FAIL stall_ostate cyc=%0d got=%h exp=%h", c, st128, CB); end
        iEn = !(c == 2 || c == 5 || c == 9);
        tick();
        if (iEn) e++;
        iEn = 1'b1;
      end
    end
    checks++; if (d != 14) begin errors++; $display("FAIL stall_done got=%0d exp=14", d); end
    checks++; if (st128 !== C1) begin errors++; $display("FAIL stall_ct got=%h exp=%h", st128, C1); end
    iEn = 1'b0;
    tick();
    checks++; if (done128 !== 1'b1) begin errors++; $display("FAIL stall_done_hold got=%b exp=1", done128); end
    iEn = 1'b1;
    tick();
    checks++; if (done128 !== 1'b0) begin errors++; $display("FAIL stall_done_clear got=%b exp=0", done128); end
  endtask

  task automatic test_reset_midrun();
    int d;
    sync_idle();
    sel = 0; iState = PT_C; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (3) tick();
    #2 iRst_n = 1'b0;
    #1;
    checks++; if (st128 !== 128'h0) begin errors++; $display("FAIL midrst_ostate got=%h exp=0", st128); end
    checks++; if (busy128 !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy128); end
    checks++; if (idx128 !== 4'd0) begin errors++; $display("FAIL midrst_idx got=%0d exp=0", idx128); end
    checks++; if (done128 !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done128); end
    tick();
    iRst_n = 1'b1;
    d = -1;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (done128 && d < 0) d = c;
      tick();
    end
    checks++; if (d != 11) begin errors++; $display("FAIL midrst_rerun_done got=%0d exp=11", d); end
    checks++; if (st128 !== C1) begin errors++; $display("FAIL midrst_rerun_ct got=%h exp=%h", st128, C1); end
  endtask

  initial begin
    iRst_n = 1'b0; iEn = 1'b1; iStart = 1'b0; iAbort = 1'b0; iState = '0;
    for (int i = 0; i < 256; i++) sbox[i] = sbox_flat[2047-8*i -: 8];
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    expand(3, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    test_reset();
    test_fips();
    test_back_to_back();
    test_abort();
    test_stall();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
